// File: rtl/ifetch_defs.sv
// Shared definitions for the instruction fetch queue: FSM states and queue entry layout.
package ifetch_defs;

   localparam int unsigned PC_W   = 32;
   localparam int unsigned INST_W = 32;

   localparam logic [INST_W-1:0] TRAP_INST = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_TRAP = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   typedef struct packed {
      logic              trap;
      logic [PC_W-1:0]   pc;
      logic [INST_W-1:0] inst;
   } entry_t;

endpackage

// File: rtl/ifetch_queue_fifo.sv
// ifq_fifo: DEPTH-entry circular buffer of {trap, pc, inst} with push/pop/clear.
module ifq_fifo
   import ifetch_defs::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic                     i_clear,
   input  entry_t                   i_data,
   output entry_t                   o_data,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full,
   output logic                     o_empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   entry_t          r_mem [DEPTH];
   logic [AW-1:0]   r_wptr;
   logic [AW-1:0]   r_rptr;
   logic [AW:0]     r_count;
   logic            w_push;
   logic            w_pop;

   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_data  = r_mem[r_rptr];

   // A push into a full buffer is legal only when the head leaves in the same cycle.
   assign w_pop  = i_pop & ~o_empty;
   assign w_push = i_push & (~o_full | w_pop);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (i_clear) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push && !i_clear) r_mem[r_wptr] <= i_data;
   end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch stage with credit-based prefetch queue and redirect handling.
// Optional same-cycle response-to-decode bypass is enabled by defining IFQ_BYPASS_EN.
module ifetch_queue
   import ifetch_defs::*;
#(
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
   parameter int unsigned DEPTH      = 4
) (
   input  logic        i_clk,
   input  logic        i_rst,
   output logic        o_mem_req,
   output logic [31:0] o_mem_addr,
   input  logic        i_mem_ready,
   input  logic        i_mem_rvalid,
   input  logic [31:0] i_mem_rdata,
   output logic        o_inst_valid,
   output logic [31:0] o_inst,
   output logic [31:0] o_inst_pc,
   output logic        o_inst_trap,
   input  logic        i_inst_ready,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   // Successive redirects can pile stale words up beyond DEPTH, so this is sized generously.
   localparam int unsigned SW = 16;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [31:0]     r_fetch_pc;
   logic [31:0]     r_resp_pc;
   logic [CW-1:0]   r_outstanding;
   logic [SW-1:0]   r_stale;

   logic            w_trap_push;
   logic            w_accept;
   logic            w_resp;
   logic            w_stale_hit;
   logic            w_credit;
   logic            w_bypass;
   logic            w_head_valid;
   logic            w_pop;
   logic            w_push;
   entry_t          w_push_data;
   entry_t          w_fifo_out;
   entry_t          w_head;
   logic [CW-1:0]   w_count;
   logic            w_full;
   logic            w_empty;

   ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (w_push),
      .i_pop   (w_pop & ~w_bypass),
      .i_clear (i_redirect),
      .i_data  (w_push_data),
      .o_data  (w_fifo_out),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign w_stale_hit = i_mem_rvalid & (r_stale != '0);
   assign w_resp      = i_mem_rvalid & (r_stale == '0);
   assign w_credit    = ~w_full & (({1'b0, w_count} + {1'b0, r_outstanding}) < (CW+1)'(DEPTH));
   assign o_mem_req   = ~i_rst & (r_state == ST_RUN) & ~i_redirect & w_credit;
   assign o_mem_addr  = r_fetch_pc;
   assign w_accept    = o_mem_req & i_mem_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_trap_push = 1'b0;
      case (r_state)
         ST_RUN:  w_state_nxt = ST_RUN;
         ST_TRAP: begin
            w_trap_push = 1'b1;
            w_state_nxt = ST_HALT;
         end
         ST_HALT: w_state_nxt = ST_HALT;
         default: w_state_nxt = ST_RUN;
      endcase
      if (i_redirect) begin
         w_trap_push = 1'b0;
         w_state_nxt = (i_redirect_pc[1:0] != 2'b00) ? ST_TRAP : ST_RUN;
      end
   end

`ifdef IFQ_BYPASS_EN
   assign w_bypass = w_empty & w_resp & ~i_redirect;
   assign w_head   = w_bypass ? '{trap: 1'b0, pc: r_resp_pc, inst: i_mem_rdata} : w_fifo_out;
`else
   assign w_bypass = 1'b0;
   assign w_head   = w_fifo_out;
`endif

   assign w_head_valid = ~i_rst & ~i_redirect & (~w_empty | w_bypass);
   assign w_pop        = w_head_valid & i_inst_ready;

   assign o_inst_valid = w_head_valid;
   assign o_inst       = w_head_valid ? w_head.inst : '0;
   assign o_inst_pc    = w_head_valid ? w_head.pc   : '0;
   assign o_inst_trap  = w_head_valid & w_head.trap;

   // The trap marker reuses resp_pc, which holds the redirect target while in TRAP.
   assign w_push      = ~i_redirect & (w_trap_push | (w_resp & ~(w_bypass & i_inst_ready)));
   assign w_push_data = w_trap_push ? '{trap: 1'b1, pc: r_resp_pc, inst: TRAP_INST}
                                    : '{trap: 1'b0, pc: r_resp_pc, inst: i_mem_rdata};

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state       <= ST_RUN;
         r_fetch_pc    <= {RESET_ADDR[31:2], 2'b00};
         r_resp_pc     <= RESET_ADDR;
         r_outstanding <= '0;
         r_stale       <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (i_redirect) begin
            r_fetch_pc    <= {i_redirect_pc[31:2], 2'b00};
            r_resp_pc     <= i_redirect_pc;
            r_outstanding <= '0;
            // A word arriving in the redirect cycle is discarded now, so it is not added to stale.
            r_stale       <= r_stale + SW'(r_outstanding) - SW'(i_mem_rvalid);
         end else begin
            if (w_accept)    r_fetch_pc <= r_fetch_pc + 32'd4;
            if (w_resp)      r_resp_pc  <= r_resp_pc + 32'd4;
            if (w_stale_hit) r_stale    <= r_stale - 1'b1;
            r_outstanding <= r_outstanding + CW'(w_accept) - CW'(w_resp);
         end
      end
   end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed self-checking bench for ifetch_queue with an in-order, fixed-latency memory responder.
module tb_ifetch_queue;

`ifdef IFQ_BYPASS_EN
   localparam int BYP = 1;
`else
   localparam int BYP = 0;
`endif

   logic        i_clk         = 1'b0;
   logic        i_rst         = 1'b1;
   logic        o_mem_req;
   logic [31:0] o_mem_addr;
   logic        i_mem_ready   = 1'b0;
   logic        i_mem_rvalid  = 1'b0;
   logic [31:0] i_mem_rdata   = '0;
   logic        o_inst_valid;
   logic [31:0] o_inst;
   logic [31:0] o_inst_pc;
   logic        o_inst_trap;
   logic        i_inst_ready  = 1'b0;
   logic        i_redirect    = 1'b0;
   logic [31:0] i_redirect_pc = '0;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int lat    = 1;

   logic [31:0] q_addr[$];
   int          q_due[$];

   ifetch_queue #(.RESET_ADDR(32'h0000_0000), .DEPTH(4)) dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .o_mem_req     (o_mem_req),
      .o_mem_addr    (o_mem_addr),
      .i_mem_ready   (i_mem_ready),
      .i_mem_rvalid  (i_mem_rvalid),
      .i_mem_rdata   (i_mem_rdata),
      .o_inst_valid  (o_inst_valid),
      .o_inst        (o_inst),
      .o_inst_pc     (o_inst_pc),
      .o_inst_trap   (o_inst_trap),
      .i_inst_ready  (i_inst_ready),
      .i_redirect    (i_redirect),
      .i_redirect_pc (i_redirect_pc)
   );

   always #5 i_clk = ~i_clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a == 32'h300) ? 32'h0000_0013 : (a ^ 32'hDEAD_0000);
   endfunction

   // Memory: returns each accepted word lat cycles after acceptance, in order.
   always @(posedge i_clk) begin
      cyc++;
      #1;
      if (!i_rst && q_due.size() > 0 && q_due[0] <= cyc) begin
         i_mem_rvalid = 1'b1;
         i_mem_rdata  = mem_word(q_addr[0]);
         void'(q_addr.pop_front());
         void'(q_due.pop_front());
      end else begin
         i_mem_rvalid = 1'b0;
         i_mem_rdata  = '0;
      end
   end

   always @(negedge i_clk) begin
      if (i_rst) begin
         q_addr.delete();
         q_due.delete();
      end else if (o_mem_req && i_mem_ready) begin
         q_addr.push_back(o_mem_addr);
         q_due.push_back(cyc + lat);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic cyc_in(input logic rdy, input logic redir, input logic [31:0] rpc, input logic irdy);
      @(posedge i_clk);
      #1;
      i_mem_ready   = rdy;
      i_redirect    = redir;
      i_redirect_pc = rpc;
      i_inst_ready  = irdy;
      @(negedge i_clk);
   endtask

   task automatic do_reset(input int l);
      @(posedge i_clk);
      #1;
      i_rst         = 1'b1;
      i_mem_ready   = 1'b0;
      i_redirect    = 1'b0;
      i_redirect_pc = '0;
      i_inst_ready  = 1'b0;
      lat           = l;
      @(negedge i_clk);
      chk1("rst_req",   o_mem_req,    1'b0);
      chk ("rst_addr",  o_mem_addr,   32'h0);
      chk1("rst_valid", o_inst_valid, 1'b0);
      chk ("rst_inst",  o_inst,       32'h0);
      chk ("rst_pc",    o_inst_pc,    32'h0);
      chk1("rst_trap",  o_inst_trap,  1'b0);
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;
   endtask

   initial begin
      int n;
      int first_k;
      int nvalid;
      logic [31:0] cap_inst;
      logic [31:0] cap_pc;

      // 1: streaming at latency 1 with decode always ready
      do_reset(1);
      for (int j = 0; j < 5; j++) begin
         cyc_in(1'b1, 1'b0, 32'h0, 1'b1);
         chk1("t1_req",  o_mem_req,  1'b1);
         chk ("t1_addr", o_mem_addr, 32'(4 * j));
         if (j >= 2 - BYP) begin
            chk1("t1_valid", o_inst_valid, 1'b1);
            chk ("t1_pc",    o_inst_pc,    32'(4 * (j - 2 + BYP)));
            chk ("t1_inst",  o_inst,       32'(4 * (j - 2 + BYP)) ^ 32'hDEAD_0000);
         end else begin
            chk1("t1_valid", o_inst_valid, 1'b0);
         end
      end

      // 2: decode stalled fills the queue, then drains in order
      do_reset(1);
      for (int j = 0; j < 4; j++) begin
         cyc_in(1'b1, 1'b0, 32'h0, 1'b0);
         chk1("t2_req",  o_mem_req,  1'b1);
         chk ("t2_addr", o_mem_addr, 32'(4 * j));
      end
      for (int j = 0; j < 3; j++) begin
         cyc_in(1'b1, 1'b0, 32'h0, 1'b0);
         chk1("t2_full_req", o_mem_req, 1'b0);
      end
      chk1("t2_head_valid", o_inst_valid, 1'b1);
      chk ("t2_head_pc",    o_inst_pc,    32'h0);
      cyc_in(1'b1, 1'b0, 32'h0, 1'b1);
      chk ("t2_pop0_pc",  o_inst_pc, 32'h0);
      chk1("t2_pop0_req", o_mem_req, 1'b0);
      cyc_in(1'b1, 1'b0, 32'h0, 1'b1);
      chk ("t2_pop1_pc",  o_inst_pc,  32'h4);
      chk1("t2_resume",   o_mem_req,  1'b1);
      chk ("t2_resume_a", o_mem_addr, 32'h10);
      cyc_in(1'b1, 1'b0, 32'h0, 1'b1);
      chk ("t2_pop2_pc", o_inst_pc, 32'h8);
      cyc_in(1'b1, 1'b0, 32'h0, 1'b1);
      chk ("t2_pop3_pc", o_inst_pc, 32'hC);
      cyc_in(1'b1, 1'b0, 32'h0, 1'b1);
      chk ("t2_pop4_pc",   o_inst_pc, 32'h10);
      chk ("t2_pop4_inst", o_inst,    32'hDEAD_0010);

      // 3: redirect with two requests in flight at latency 3 (also a mid-run reset)
      do_reset(3);
      cyc_in(1'b1, 1'b0, 32'h0, 1'b1);
      chk ("t3_a_addr", o_mem_addr, 32'h0);
      cyc_in(1'b1, 1'b0, 32'h0, 1'b1);
      chk ("t3_b_addr", o_mem_addr, 32'h4);
      cyc_in(1'b1, 1'b1, 32'h100, 1'b1);
      chk1("t3_redir_req",   o_mem_req,    1'b0);
      chk1("t3_redir_valid", o_inst_valid, 1'b0);
      cyc_in(1'b1, 1'b0, 32'h0, 1'b1);
      chk1("t3_d_req",   o_mem_req,    1'b1);
      chk ("t3_d_addr",  o_mem_addr,   32'h100);
      chk1("t3_d_valid", o_inst_valid, 1'b0);
      cyc_in(1'b1, 1'b0, 32'h0, 1'b1);
      chk ("t3_e_addr",  o_mem_addr,   32'h104);
      chk1("t3_e_valid", o_inst_valid, 1'b0);
      n = 0;
      while (o_inst_valid !== 1'b1 && n < 8) begin
         cyc_in(1'b1, 1'b0, 32'h0, 1'b1);
         n++;
      end
      chk ("t3_wait_cycles", 32'(n), 32'(3 - BYP));
      chk1("t3_valid", o_inst_valid, 1'b1);
      chk ("t3_pc",    o_inst_pc,    32'h100);
      chk ("t3_inst",  o_inst,       32'hDEAD_0100);

      // 4: misaligned redirect emits one trap marker and halts; aligned redirect restarts
      do_reset(1);
      cyc_in(1'b1, 1'b0, 32'h0, 1'b0);
      chk ("t4_a_addr", o_mem_addr, 32'h0);
      cyc_in(1'b1, 1'b1, 32'h102, 1'b0);
      chk1("t4_b_req", o_mem_req, 1'b0);
      cyc_in(1'b1, 1'b0, 32'h0, 1'b0);
      chk1("t4_c_req",   o_mem_req,    1'b0);
      chk1("t4_c_valid", o_inst_valid, 1'b0);
      cyc_in(1'b1, 1'b0, 32'h0, 1'b0);
      chk1("t4_d_valid", o_inst_valid, 1'b1);
      chk1("t4_d_trap",  o_inst_trap,  1'b1);
      chk ("t4_d_pc",    o_inst_pc,    32'h102);
      chk ("t4_d_inst",  o_inst,       32'h0);
      chk1("t4_d_req",   o_mem_req,    1'b0);
      cyc_in(1'b1, 1'b0, 32'h0, 1'b1);
      chk1("t4_e_trap", o_inst_trap, 1'b1);
      for (int j = 0; j < 3; j++) begin
         cyc_in(1'b1, 1'b0, 32'h0, 1'b1);
         chk1("t4_halt_req",   o_mem_req,    1'b0);
         chk1("t4_halt_valid", o_inst_valid, 1'b0);
      end
      cyc_in(1'b1, 1'b1, 32'h200, 1'b1);
      chk1("t4_redir_req", o_mem_req, 1'b0);
      cyc_in(1'b1, 1'b0, 32'h0, 1'b1);
      chk1("t4_restart_req",  o_mem_req,  1'b1);
      chk ("t4_restart_addr", o_mem_addr, 32'h200);
      cyc_in(1'b1, 1'b0, 32'h0, 1'b1);
      chk ("t4_next_addr", o_mem_addr, 32'h204);

      // 5: memory backpressure holds the address stable
      do_reset(1);
      cyc_in(1'b1, 1'b0, 32'h0, 1'b1);
      cyc_in(1'b1, 1'b0, 32'h0, 1'b1);
      for (int j = 0; j < 5; j++) begin
         cyc_in(1'b0, 1'b0, 32'h0, 1'b1);
         chk1("t5_hold_req",  o_mem_req,  1'b1);
         chk ("t5_hold_addr", o_mem_addr, 32'h8);
      end
      cyc_in(1'b1, 1'b0, 32'h0, 1'b1);
      chk ("t5_accept_addr", o_mem_addr, 32'h8);
      cyc_in(1'b1, 1'b0, 32'h0, 1'b1);
      chk ("t5_next_addr", o_mem_addr, 32'hC);

      // 6: single word into an empty queue
      do_reset(1);
      cyc_in(1'b0, 1'b1, 32'h300, 1'b1);
      chk1("t6_redir_valid", o_inst_valid, 1'b0);
      cyc_in(1'b1, 1'b0, 32'h0, 1'b1);
      chk ("t6_addr", o_mem_addr, 32'h300);
      first_k  = -1;
      nvalid   = 0;
      cap_inst = '0;
      cap_pc   = '0;
      for (int k = 0; k < 3; k++) begin
         cyc_in(1'b0, 1'b0, 32'h0, 1'b1);
         if (o_inst_valid === 1'b1) begin
            nvalid++;
            if (first_k < 0) begin
               first_k  = k;
               cap_inst = o_inst;
               cap_pc   = o_inst_pc;
            end
         end
      end
      chk("t6_latency", 32'(first_k), 32'(1 - BYP));
      chk("t6_nvalid",  32'(nvalid),  32'd1);
      chk("t6_inst",    cap_inst,     32'h0000_0013);
      chk("t6_pc",      cap_pc,       32'h300);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
